// File: rtl/coherence_bus_arbiter.sv
// Snoop-bus arbiter and coherence transaction sequencer for NPROC caches.
// Ports: clk/reset_n; req, req_op, snoop_hit, snoop_mod, inv_ack, wb_done in;
//   grant, bus_valid, bus_op, shared, read_done, invalidate, all_inv_done,
//   send_abort, busy, timeout_err out. Optional watchdog: COH_ARB_TIMEOUT_EN.
module coherence_bus_arbiter #(
    parameter int NPROC   = 2,
    parameter int MEM_LAT = 3,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NPROC-1:0]   req,
    input  logic [2*NPROC-1:0] req_op,
    input  logic [NPROC-1:0]   snoop_hit,
    input  logic [NPROC-1:0]   snoop_mod,
    input  logic [NPROC-1:0]   inv_ack,
    input  logic               wb_done,
    output logic [NPROC-1:0]   grant,
    output logic               bus_valid,
    output logic [1:0]         bus_op,
    output logic               shared,
    output logic               read_done,
    output logic               invalidate,
    output logic               all_inv_done,
    output logic               send_abort,
    output logic               busy,
    output logic               timeout_err
);
    localparam int PW = (NPROC > 1) ? $clog2(NPROC) : 1;
    localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [1:0] OP_WM = 2'b10;
    localparam logic [1:0] OP_WH = 2'b11;

    if (NPROC < 2 || MEM_LAT < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("coherence_bus_arbiter: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE, BCAST, SNOOP, MEM_READ, INV_WAIT, ABORT, DONE
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, winner, rr_idx, hi_idx, lo_idx;
    logic             hi_ok;
    logic [MW-1:0]    mem_cnt;
    logic [NPROC-1:0] ack_mask;
    logic             inv_first;
    logic             mem_last, inv_cover, snoop_abort, timed_out;

    // Lowest requester at or above ptr, else lowest requester overall.
    always_comb begin
        hi_ok  = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (req[i]) lo_idx = PW'(i);
            if (req[i] && PW'(i) >= ptr) begin
                hi_ok  = 1'b1;
                hi_idx = PW'(i);
            end
        end
        rr_idx = hi_ok ? hi_idx : lo_idx;
    end

    assign mem_last    = (mem_cnt == MW'(MEM_LAT - 1));
    assign snoop_abort = |(snoop_mod & ~grant);
    // The requester's own bit is treated as already acknowledged.
    assign inv_cover   = &(ack_mask | inv_ack | grant);

`ifdef COH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    assign timed_out = (to_cnt == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (|req) state_nxt = BCAST;
            BCAST:    state_nxt = SNOOP;
            SNOOP: begin
                if (snoop_abort)          state_nxt = ABORT;
                else if (bus_op == OP_WH) state_nxt = INV_WAIT;
                else                      state_nxt = MEM_READ;
            end
            MEM_READ: if (mem_last)
                state_nxt = (bus_op == OP_WM) ? INV_WAIT : DONE;
            INV_WAIT: if (inv_cover || timed_out) state_nxt = DONE;
            ABORT:    if (wb_done || timed_out) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign bus_valid  = (state == BCAST);
    assign read_done  = (state == MEM_READ) && mem_last;
    assign invalidate = (state == INV_WAIT) && inv_first;
    assign send_abort = (state == ABORT);
    assign busy       = (state != IDLE);

    // Transaction context is dropped on the edge into DONE so that grant
    // is already low during the DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant        <= '0;
            bus_op       <= '0;
            winner       <= '0;
            ptr          <= '0;
            shared       <= 1'b0;
            mem_cnt      <= '0;
            ack_mask     <= '0;
            inv_first    <= 1'b0;
            all_inv_done <= 1'b0;
        end else begin
            all_inv_done <= 1'b0;
            if (state == IDLE && |req) begin
                grant  <= NPROC'(1) << rr_idx;
                bus_op <= req_op[{rr_idx, 1'b0} +: 2];
                winner <= rr_idx;
            end
            if (state == SNOOP) shared <= |(snoop_hit & ~grant);
            mem_cnt <= (state == MEM_READ) ? mem_cnt + 1'b1 : '0;
            if (state == INV_WAIT) ack_mask <= ack_mask | (inv_ack & ~grant);
            else                   ack_mask <= '0;
            inv_first <= (state_nxt == INV_WAIT) && (state != INV_WAIT);
            if (state == INV_WAIT && inv_cover) all_inv_done <= 1'b1;
            if (state_nxt == DONE) begin
                grant  <= '0;
                shared <= 1'b0;
                bus_op <= '0;
                ptr    <= (winner == PW'(NPROC - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

`ifdef COH_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == INV_WAIT || state == ABORT) && state_nxt == state)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
            // A completion on the same cycle wins over the watchdog.
            if (timed_out && ((state == INV_WAIT && !inv_cover) ||
                              (state == ABORT && !wb_done)))
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Randomized scoreboard bench for coherence_bus_arbiter.
// Expected transaction timelines are queued at issue; a monitor checks them.
module tb_coherence_bus_arbiter;
    localparam int N   = 3;
    localparam int ML  = 3;
    localparam int NTX = 200;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req, snoop_hit, snoop_mod, inv_ack;
    logic [2*N-1:0] req_op;
    logic         wb_done;
    logic [N-1:0] grant;
    logic         bus_valid, shared, read_done, invalidate;
    logic         all_inv_done, send_abort, busy, timeout_err;
    logic [1:0]   bus_op;

    coherence_bus_arbiter #(.NPROC(N), .MEM_LAT(ML), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_op(req_op),
        .snoop_hit(snoop_hit), .snoop_mod(snoop_mod), .inv_ack(inv_ack),
        .wb_done(wb_done), .grant(grant), .bus_valid(bus_valid),
        .bus_op(bus_op), .shared(shared), .read_done(read_done),
        .invalidate(invalidate), .all_inv_done(all_inv_done),
        .send_abort(send_abort), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Event offsets are in cycles relative to the bus_valid cycle; -1 = never.
    typedef struct {
        int winner;
        int op;
        int shr;
        int rd_off;
        int inv_off;
        int aid_off;
        int ab_len;
        int len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   in_txn = 1'b0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(int own, int op, int hit, int mod,
                                   int dmax, int w);
        exp_t e;
        int others;
        others    = ((1 << N) - 1) & ~(1 << own);
        e.winner  = own;
        e.op      = op;
        e.shr     = ((hit & others) != 0) ? 1 : 0;
        e.rd_off  = -1;
        e.inv_off = -1;
        e.aid_off = -1;
        e.ab_len  = 0;
        if ((mod & others) != 0) begin
            e.ab_len = w + 1;
            e.len    = w + 4;
        end else if (op == 3) begin
            e.inv_off = 2;
            e.aid_off = 3 + dmax;
            e.len     = 4 + dmax;
        end else begin
            e.rd_off = 1 + ML;
            if (op == 2) begin
                e.inv_off = 2 + ML;
                e.aid_off = 3 + ML + dmax;
                e.len     = 4 + ML + dmax;
            end else begin
                e.len = 3 + ML;
            end
        end
        return e;
    endfunction

    function automatic int rr_pick(int mask, int ptr);
        for (int k = 0; k < N; k++)
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        return 0;
    endfunction

    function automatic logic [31:0] out_vec();
        return 32'({grant, bus_valid, bus_op, shared, read_done, invalidate,
                    all_inv_done, send_abort, busy, timeout_err});
    endfunction

    exp_t cur;
    int   b_cyc, obs_rd, obs_inv, obs_aid, n_sa;

    always @(negedge clk) begin
        int off;
        cyc++;
        if (mon_en) begin
            if (bus_valid) begin
                chk("sb_nonempty", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    cur     = sb.pop_front();
                    in_txn  = 1'b1;
                    b_cyc   = cyc;
                    obs_rd  = -1;
                    obs_inv = -1;
                    obs_aid = -1;
                    n_sa    = 0;
                    chk("grant", 32'(grant), 1 << cur.winner);
                    chk("bus_op", 32'(bus_op), cur.op);
                end
            end else if (in_txn) begin
                off = cyc - b_cyc;
                if (off == 2) chk("shared", 32'(shared), cur.shr);
                if (off == cur.len - 2 && off > 2) begin
                    chk("shared_hold", 32'(shared), cur.shr);
                    chk("bus_op_hold", 32'(bus_op), cur.op);
                end
                if (off == cur.len - 1) chk("done_grant", 32'(grant), 0);
                if (read_done)    obs_rd  = (obs_rd  == -1) ? off : -2;
                if (invalidate)   obs_inv = (obs_inv == -1) ? off : -2;
                if (all_inv_done) obs_aid = (obs_aid == -1) ? off : -2;
                if (send_abort)   n_sa++;
                if (!busy || off > 60) begin
                    chk("txn_len", off, cur.len);
                    chk("read_done_at", obs_rd, cur.rd_off);
                    chk("invalidate_at", obs_inv, cur.inv_off);
                    chk("all_inv_done_at", obs_aid, cur.aid_off);
                    chk("send_abort_len", n_sa, cur.ab_len);
                    chk("idle_grant", 32'(grant), 0);
                    chk("timeout_err", 32'(timeout_err), 0);
                    in_txn = 1'b0;
                end
            end
        end
    end

    initial begin
        int issued, gap, guard, inv_k, ab_k, own, dmax, w, op, mask, ptr_m, k;
        int dl[N];
        logic [N-1:0] cur_hit, cur_mod;
        logic [2*N-1:0] ops;
        logic prev_bv, prev_sa;

        reset_n = 1'b0;
        req = '0; req_op = '0; snoop_hit = '0; snoop_mod = '0;
        inv_ack = '0; wb_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", out_vec(), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        issued = 0; gap = 0; guard = 0; inv_k = -1; ab_k = -1;
        own = 0; dmax = 0; w = 0; ptr_m = 0;
        cur_hit = '0; cur_mod = '0; prev_bv = 1'b0; prev_sa = 1'b0;
        foreach (dl[i]) dl[i] = 0;

        while (guard < 20000) begin
            @(negedge clk);
            guard++;
            if (issued == NTX && sb.size() == 0 && !busy && !in_txn) break;
            // Inputs are noise except where the current phase consumes them.
            req       = N'($urandom);
            req_op    = (2*N)'($urandom);
            snoop_hit = N'($urandom);
            snoop_mod = N'($urandom);
            inv_ack   = N'($urandom);
            wb_done   = 1'($urandom);
            if (!busy) begin
                if (issued < NTX && gap == 0) begin
                    mask    = $urandom_range(1, (1 << N) - 1);
                    ops     = (2*N)'($urandom);
                    own     = rr_pick(mask, ptr_m);
                    op      = int'((ops >> (2 * own)) & 3);
                    cur_hit = N'($urandom);
                    cur_mod = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
                    dmax    = 0;
                    for (int i = 0; i < N; i++) begin
                        dl[i] = $urandom_range(0, 5);
                        if (i != own && dl[i] > dmax) dmax = dl[i];
                    end
                    w = $urandom_range(0, 5);
                    sb.push_back(model(own, op, int'(cur_hit), int'(cur_mod),
                                       dmax, w));
                    ptr_m  = (own + 1) % N;
                    req    = N'(mask);
                    req_op = ops;
                    issued++;
                    gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                end else begin
                    req = '0;
                    if (gap > 0) gap--;
                end
            end
            if (prev_bv) begin
                snoop_hit = cur_hit;
                snoop_mod = cur_mod;
            end
            if (invalidate) inv_k = 0;
            if (inv_k >= 0) begin
                for (int i = 0; i < N; i++)
                    if (i != own) inv_ack[i] = (dl[i] == inv_k);
                inv_k = (inv_k == dmax) ? -1 : inv_k + 1;
            end
            if (send_abort && !prev_sa) ab_k = 0;
            if (ab_k >= 0) begin
                wb_done = (ab_k == w);
                ab_k = (ab_k == w) ? -1 : ab_k + 1;
            end
            prev_bv = bus_valid;
            prev_sa = send_abort;
        end
        chk("drain_pending", sb.size() + int'(in_txn), 0);
        chk("tx_issued", issued, NTX);

        // Directed: reset in the middle of a memory read restores pointer 0.
        mon_en = 1'b0;
        req = '0; req_op = '0; snoop_hit = '0; snoop_mod = '0;
        inv_ack = '0; wb_done = 1'b0;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        req = 3'b010;
        @(negedge clk);
        req = '0;
        chk("p1_grant", 32'(grant), 32'b010);
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("p1_finished", 32'(busy), 0);
        req    = 3'b001;
        req_op = 6'b000001;
        @(negedge clk);
        req = '0;
        chk("p0_grant", 32'(grant), 32'b001);
        @(negedge clk);
        @(negedge clk);
        chk("mr1_no_read_done", 32'(read_done), 0);
        @(negedge clk);
        chk("mr2_busy", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1 chk("midreset_outputs", out_vec(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        req = 3'b110;
        @(negedge clk);
        chk("post_reset_grant", 32'(grant), 32'b010);
        chk("post_reset_bus_valid", 32'(bus_valid), 1);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
